read_requester: RTL

READ_REQUESTER -- requirements
Module: read_requester

---
 rtl/read_requester_pkg.sv | 20 ++
 rtl/req_timer.sv | 34 +++
 rtl/read_requester.sv | 130 +++++++++++++
 3 files changed

// File: rtl/read_requester_pkg.sv
// Shared definitions for the burst read requester: FSM state encoding,
// default abort timeout and the burst-length decode helper.
package read_requester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_REL  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam int DEFAULT_TIMEOUT = 8;

    // A length field of zero encodes the maximum burst of 16 reads.
    function automatic logic [4:0] burst_count(input logic [3:0] len);
        return (len == 4'd0) ? 5'd16 : {1'b0, len};
    endfunction

endpackage

// File: rtl/req_timer.sv
// Cycle counter for time spent waiting on an acknowledge; flags expiry on
// the TIMEOUT-th enabled cycle after a clear.
module req_timer
    import read_requester_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int           W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;

    // NOTE: sequential state is written with <= so every register samples
    // the values that existed before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count holds the number of completed cycles, so the current cycle
    // is the TIMEOUT-th one when the count reaches TIMEOUT-1.
    assign o_expired = (r_count >= LAST);

endmodule

// File: rtl/read_requester.sv
// Burst read requester: issues rd to a read/ack responder once per transfer,
// captures data strobes, and reports completion or timeout abort.
module read_requester
    import read_requester_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] burst_len,
    output logic       rd,
    input  logic       rd_data,
    input  logic       ack,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [4:0] xfer_cnt
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_remaining;
    logic [4:0] r_xfer_cnt;
    logic [7:0] r_dout;
    logic       r_dout_valid;
    logic       w_in_req;
    logic       w_expired;
    logic       w_rd;
    logic       w_busy;
    logic       w_done;
    logic       w_timeout;

    assign w_in_req = (r_state == ST_REQ);

    req_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_req_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_in_req),
        .i_enable (w_in_req),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block can infer a latch.
    always_comb begin
        w_next    = r_state;
        w_rd      = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = ST_REQ;
            end
            ST_REQ: begin
                w_rd = 1'b1;
                // An acknowledge on the expiry edge still completes the transfer.
                if (ack) begin
                    w_next = (r_remaining > 5'd1) ? ST_REL : ST_DONE;
                end else if (w_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_REL:  w_next = ST_REQ;
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_timeout = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= 8'd0;
            r_dout_valid <= 1'b0;
            r_xfer_cnt   <= 5'd0;
            r_remaining  <= 5'd0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= burst_count(burst_len);
                        r_xfer_cnt  <= 5'd0;
                    end
                end
                ST_REQ: begin
                    if (rd_data) begin
                        r_dout       <= din;
                        r_dout_valid <= 1'b1;
                    end
                    if (ack) begin
                        r_xfer_cnt  <= r_xfer_cnt + 5'd1;
                        r_remaining <= r_remaining - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd         = w_rd;
    assign busy       = w_busy;
    assign done       = w_done;
    assign timeout    = w_timeout;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign xfer_cnt   = r_xfer_cnt;

endmodule
